// File: rtl/input_frame_loader.sv
// Packs a host stream of square 8-bit frames into the engine's input SRAM,
// terminates the batch with a sentinel, starts the engine and waits for it.
module input_frame_loader #(
    parameter int ADDR_W = 12,
    parameter int MAX_N  = 64,
    parameter int MIN_N  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_valid,
    input  logic [6:0]        frame_n,
    output logic              frame_ready,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    input  logic              batch_valid,
    output logic              batch_ready,
    output logic              input_sram_write_enable,
    output logic [ADDR_W-1:0] input_sram_write_addresss,
    output logic [15:0]       input_sram_write_data,
    output logic              dut_run,
    input  logic              dut_busy,
    output logic              load_err,
    output logic              batch_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PIX     = 3'd1;
    localparam logic [2:0] S_TERM    = 3'd2;
    localparam logic [2:0] S_KICK    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [12:0]       pix_cnt_q, pix_cnt_d;
    logic [7:0]        held_q, held_d;
    logic              has_frame_q, has_frame_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              run_q, run_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [13:0] nn;
    logic        fits;
    logic        n_legal;
    logic        hdr_fire;
    logic        pix_fire;
    logic        batch_fire;

    // Handshake rule: a transfer happens on a rising edge where valid & ready are both high.
    // batch_ready yields to a simultaneous header so a frame is never lost to a batch end.
    assign frame_ready = (state_q == S_IDLE) & ~reset;
    assign batch_ready = (state_q == S_IDLE) & ~reset & ~frame_valid;
    assign pix_ready   = (state_q == S_PIX) & ~reset;

    assign hdr_fire   = frame_valid & frame_ready;
    assign pix_fire   = pix_valid & pix_ready;
    assign batch_fire = batch_valid & batch_ready;

    // The frame plus a following sentinel must still fit below the top of the SRAM.
    assign nn      = 14'(frame_n) * 14'(frame_n);
    assign fits    = (32'(ptr_q) + 32'(nn[13:1]) + 32'd2) <= (32'd1 << ADDR_W);
    assign n_legal = ~frame_n[0] && (frame_n >= 7'(MIN_N)) && (frame_n <= 7'(MAX_N)) && fits;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pix_cnt_d   = pix_cnt_q;
        held_d      = held_q;
        has_frame_d = has_frame_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        run_d       = 1'b0;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hdr_fire) begin
                    if (n_legal) begin
                        we_d        = 1'b1;
                        addr_d      = ptr_q;
                        data_d      = {9'b0, frame_n};
                        ptr_d       = ptr_q + 1'b1;
                        pix_cnt_d   = nn[12:0];
                        has_frame_d = 1'b1;
                        state_d     = S_PIX;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (batch_fire) begin
                    state_d = S_TERM;
                end
            end
            S_PIX: begin
                if (pix_fire) begin
                    // An even remaining count means this byte starts a new pair.
                    if (!pix_cnt_q[0]) begin
                        held_d = pix_data;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = ptr_q;
                        data_d = {held_q, pix_data};
                        ptr_d  = ptr_q + 1'b1;
                    end
                    pix_cnt_d = pix_cnt_q - 1'b1;
                    if (pix_cnt_q == 13'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TERM: begin
                we_d   = 1'b1;
                addr_d = ptr_q;
                data_d = 16'h00FF;
                if (has_frame_q) begin
                    state_d = S_KICK;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_KICK: begin
                run_d   = 1'b1;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (dut_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!dut_busy) begin
                    done_d      = 1'b1;
                    err_d       = 1'b0;
                    ptr_d       = '0;
                    has_frame_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            pix_cnt_q   <= '0;
            held_q      <= '0;
            has_frame_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pix_cnt_q   <= pix_cnt_d;
            held_q      <= held_d;
            has_frame_q <= has_frame_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            run_q       <= run_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign input_sram_write_enable   = we_q;
    assign input_sram_write_addresss = addr_q;
    assign input_sram_write_data     = data_q;
    assign dut_run                   = run_q;
    assign load_err                  = err_q;
    assign batch_done                = done_q;

endmodule
